// File: rtl/exc_vector_if.sv
// Bus between the main control / memory side and the exception sequencer.
// The master drives the exception requests, pass-through controls and read data.
interface exc_vector_if;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [2:0]  cpu_iord_sel;
  logic        cpu_mem_wr;
  logic [31:0] mem_data;
  logic [2:0]  iord_sel;
  logic        mem_wr;
  logic        epc_write;
  logic        pc_write;
  logic [31:0] pc_data;
  logic [1:0]  exc_cause;
  logic        busy;
  logic        done;

  modport master (
    output exc_opcode, exc_overflow, exc_div0, cpu_iord_sel, cpu_mem_wr, mem_data,
    input  iord_sel, mem_wr, epc_write, pc_write, pc_data, exc_cause, busy, done
  );

  modport slave (
    input  exc_opcode, exc_overflow, exc_div0, cpu_iord_sel, cpu_mem_wr, mem_data,
    output iord_sel, mem_wr, epc_write, pc_write, pc_data, exc_cause, busy, done
  );
endinterface

// File: rtl/exc_vector_ctrl.sv
// Exception sequencer: saves EPC, fetches the vector byte for the latched cause,
// loads PC with it, then returns the memory address path to the main control unit.
module exc_vector_ctrl #(
  parameter int unsigned MEM_WAIT = 1
) (
  input logic         clk,
  input logic         reset,
  exc_vector_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SAVE, WAIT, LOAD, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t      state_reg;
  logic [1:0]  cause_reg;
  logic [3:0]  wait_cnt_reg;
  logic        epc_write_reg;
  logic        pc_write_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] pc_data_reg;
  logic [31:0] vector_data;

  assign vector_data = {24'b0, bus.mem_data[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cause_reg     <= 2'b00;
      wait_cnt_reg  <= 4'd0;
      epc_write_reg <= 1'b0;
      pc_write_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      pc_data_reg   <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.exc_opcode || bus.exc_overflow || bus.exc_div0) begin
            // Cause code doubles as the vector select (01/10/11 -> 253/254/255)
            if (bus.exc_opcode)        cause_reg <= 2'b01;
            else if (bus.exc_overflow) cause_reg <= 2'b10;
            else                       cause_reg <= 2'b11;
            epc_write_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= SAVE;
          end
        end
        SAVE: begin
          epc_write_reg <= 1'b0;
          wait_cnt_reg  <= WAIT_INIT;
          state_reg     <= WAIT;
        end
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 4'd1;
          if (wait_cnt_reg == 4'd1) begin
            pc_write_reg <= 1'b1;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          pc_write_reg <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b1;
          pc_data_reg  <= vector_data;
          state_reg    <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // busy covers exactly SAVE..LOAD, the cycles in which the sequencer owns the path
  assign bus.iord_sel  = busy_reg ? {1'b0, cause_reg} : bus.cpu_iord_sel;
  assign bus.mem_wr    = busy_reg ? 1'b0 : bus.cpu_mem_wr;
  assign bus.epc_write = epc_write_reg;
  assign bus.pc_write  = pc_write_reg;
  // Memory data is only valid during LOAD, so the PC value passes through then
  assign bus.pc_data   = pc_write_reg ? vector_data : pc_data_reg;
  assign bus.exc_cause = cause_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_exc_vector_ctrl.sv
// Directed bench for exc_vector_ctrl: one instance with MEM_WAIT=1, one with MEM_WAIT=3.
module tb_exc_vector_ctrl;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  exc_vector_if bus1 ();
  exc_vector_if bus3 ();

  exc_vector_ctrl #(.MEM_WAIT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  exc_vector_ctrl #(.MEM_WAIT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus1.exc_opcode = 1'b0; bus1.exc_overflow = 1'b0; bus1.exc_div0 = 1'b0;
    bus1.cpu_iord_sel = 3'b101; bus1.cpu_mem_wr = 1'b1; bus1.mem_data = 32'd0;
    bus3.exc_opcode = 1'b0; bus3.exc_overflow = 1'b0; bus3.exc_div0 = 1'b0;
    bus3.cpu_iord_sel = 3'b110; bus3.cpu_mem_wr = 1'b1; bus3.mem_data = 32'd0;

    // 1: reset state with pass-through
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_iord", 32'(bus1.iord_sel), 32'h5);
    check("rst_memwr", 32'(bus1.mem_wr), 32'h1);
    check("rst_busy", 32'(bus1.busy), 32'h0);
    check("rst_cause", 32'(bus1.exc_cause), 32'h0);
    check("rst_pcdata", bus1.pc_data, 32'h0);
    check("rst_flags", {28'd0, bus1.epc_write, bus1.pc_write, bus1.done, bus3.busy}, 32'h0);
    $display("[TB] reset/pass-through phase done");

    // 2: overflow pulse, MEM_WAIT=1
    bus1.exc_overflow = 1'b1;
    tick();                                   // SAVE
    bus1.exc_overflow = 1'b0;
    check("ovf_save_epc", 32'(bus1.epc_write), 32'h1);
    check("ovf_save_iord", 32'(bus1.iord_sel), 32'h2);
    check("ovf_save_busy", 32'(bus1.busy), 32'h1);
    check("ovf_save_memwr", 32'(bus1.mem_wr), 32'h0);
    check("ovf_save_pcw", 32'(bus1.pc_write), 32'h0);
    tick();                                   // WAIT
    bus1.mem_data = 32'hFFFF_FF3C;
    check("ovf_wait_epc", 32'(bus1.epc_write), 32'h0);
    check("ovf_wait_iord", 32'(bus1.iord_sel), 32'h2);
    check("ovf_wait_pcw", 32'(bus1.pc_write), 32'h0);
    tick();                                   // LOAD
    check("ovf_load_pcw", 32'(bus1.pc_write), 32'h1);
    check("ovf_load_pcdata", bus1.pc_data, 32'h0000_003C);
    check("ovf_load_busy", 32'(bus1.busy), 32'h1);
    check("ovf_load_done", 32'(bus1.done), 32'h0);
    tick();                                   // DONE (N+4)
    bus1.mem_data = 32'h0000_0077;
    check("ovf_done_done", 32'(bus1.done), 32'h1);
    check("ovf_done_busy", 32'(bus1.busy), 32'h0);
    check("ovf_done_pcw", 32'(bus1.pc_write), 32'h0);
    check("ovf_done_iord", 32'(bus1.iord_sel), 32'h5);
    check("ovf_done_memwr", 32'(bus1.mem_wr), 32'h1);
    check("ovf_done_cause", 32'(bus1.exc_cause), 32'h2);
    check("ovf_hold_pcdata", bus1.pc_data, 32'h0000_003C);
    tick();                                   // IDLE
    check("ovf_idle_done", 32'(bus1.done), 32'h0);
    check("ovf_idle_cause", 32'(bus1.exc_cause), 32'h2);
    $display("[TB] overflow sequence MEM_WAIT=1 done");

    // 3: priority
    bus1.exc_opcode = 1'b1; bus1.exc_overflow = 1'b1; bus1.exc_div0 = 1'b1;
    tick();                                   // SAVE
    bus1.exc_opcode = 1'b0; bus1.exc_overflow = 1'b0; bus1.exc_div0 = 1'b0;
    check("pri_all_iord", 32'(bus1.iord_sel), 32'h1);
    check("pri_all_cause", 32'(bus1.exc_cause), 32'h1);
    tick(); tick(); tick(); tick();           // WAIT, LOAD, DONE, IDLE
    check("pri_all_idle_busy", 32'(bus1.busy), 32'h0);
    bus1.exc_overflow = 1'b1; bus1.exc_div0 = 1'b1;
    tick();
    bus1.exc_overflow = 1'b0; bus1.exc_div0 = 1'b0;
    check("pri_od_iord", 32'(bus1.iord_sel), 32'h2);
    check("pri_od_cause", 32'(bus1.exc_cause), 32'h2);
    tick(); tick(); tick(); tick();
    $display("[TB] priority phase done");

    // 4+5: div0 with MEM_WAIT=3, opcode raised during WAIT and dropped before DONE
    bus3.exc_div0 = 1'b1;
    tick();                                   // SAVE (N+1)
    bus3.exc_div0 = 1'b0;
    check("d0_save_iord", 32'(bus3.iord_sel), 32'h3);
    check("d0_save_memwr", 32'(bus3.mem_wr), 32'h0);
    check("d0_save_epc", 32'(bus3.epc_write), 32'h1);
    for (int i = 0; i < 3; i++) begin         // WAIT N+2..N+4
      tick();
      if (i == 0) bus3.exc_opcode = 1'b1;
      check($sformatf("d0_wait%0d_iord", i), 32'(bus3.iord_sel), 32'h3);
      check($sformatf("d0_wait%0d_memwr", i), 32'(bus3.mem_wr), 32'h0);
      check($sformatf("d0_wait%0d_pcw", i), 32'(bus3.pc_write), 32'h0);
      check($sformatf("d0_wait%0d_busy", i), 32'(bus3.busy), 32'h1);
    end
    bus3.mem_data = 32'h1234_56A5;
    tick();                                   // LOAD (N+5)
    bus3.exc_opcode = 1'b0;
    check("d0_load_pcw", 32'(bus3.pc_write), 32'h1);
    check("d0_load_pcdata", bus3.pc_data, 32'h0000_00A5);
    check("d0_load_iord", 32'(bus3.iord_sel), 32'h3);
    check("d0_load_memwr", 32'(bus3.mem_wr), 32'h0);
    tick();                                   // DONE
    check("d0_done_done", 32'(bus3.done), 32'h1);
    check("d0_done_pcw", 32'(bus3.pc_write), 32'h0);
    check("d0_done_cause", 32'(bus3.exc_cause), 32'h3);
    check("d0_done_memwr", 32'(bus3.mem_wr), 32'h1);
    tick();                                   // IDLE, opcode request was dropped
    check("d0_idle_busy", 32'(bus3.busy), 32'h0);
    tick();
    check("d0_ignored_epc", 32'(bus3.epc_write), 32'h0);
    check("d0_ignored_cause", 32'(bus3.exc_cause), 32'h3);
    check("d0_ignored_pcw", 32'(bus3.pc_write), 32'h0);
    $display("[TB] div0 sequence MEM_WAIT=3 with ignored opcode done");

    // 6: reset during WAIT
    bus3.exc_div0 = 1'b1;
    tick();                                   // SAVE
    bus3.exc_div0 = 1'b0;
    tick();                                   // WAIT
    check("rw_wait_busy", 32'(bus3.busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_busy", 32'(bus3.busy), 32'h0);
    check("rw_cause", 32'(bus3.exc_cause), 32'h0);
    check("rw_iord", 32'(bus3.iord_sel), 32'h6);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rw_pcw%0d", i), 32'(bus3.pc_write), 32'h0);
      check($sformatf("rw_done%0d", i), 32'(bus3.done), 32'h0);
      tick();
    end
    check("rw_final_busy", 32'(bus3.busy), 32'h0);
    $display("[TB] reset-in-WAIT phase done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exc_vector_ctrl.md
Name: exc_vector_ctrl

Overview:
Exception sequencer for the multicycle CPU's memory address path. In normal operation it passes the main control unit's IorD select and memory write enable straight through to the memory address mux and the memory. On an exception it takes over the mux and performs these steps in order:
- writes EPC;
- addresses the fixed vector byte (253, 254 or 255);
- waits out the memory latency;
- loads PC with the zero-extended vector byte;
- hands control back to the main control unit.

Parameters:
MEM_WAIT, 1, memory read latency in cycles between address presentation and valid mem_data; legal range 1..15.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
exc_opcode  in  1  nonexistent-opcode exception request (level, sampled in IDLE)
exc_overflow  in  1  arithmetic overflow exception request
exc_div0  in  1  divide-by-zero exception request
cpu_iord_sel  in  3  IorD select from main control (pass-through)
cpu_mem_wr  in  1  memory write enable from main control (pass-through)
mem_data  in  32  memory read data; only bits [7:0] used
iord_sel  out  3  select to memory address mux
mem_wr  out  1  memory write enable to memory
epc_write  out  1  EPC register load enable
pc_write  out  1  PC load enable (exception path)
pc_data  out  32  value for PC on exception path
exc_cause  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div0
busy  out  1  high while the sequencer owns the memory path; main control must stall
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Mux select encoding driven on iord_sel: 000 PC (Data_0), 001 addr 253, 010 addr 254, 011 addr 255, 100/101/110 Data_4/5/6.
- Cause-to-vector mapping: opcode -> 001 (253), overflow -> 010 (254), div0 -> 011 (255).
- States: IDLE, SAVE, WAIT, LOAD, DONE. All outputs are decoded from state and registers; none are combinational from exc_* inputs.
- Reset values:
  - state IDLE;
  - exc_cause 00;
  - wait counter 0;
  - epc_write, pc_write, busy and done all 0;
  - pc_data 0;
  - iord_sel and mem_wr equal to the pass-through inputs, because the block is in IDLE.
- IDLE:
  - iord_sel=cpu_iord_sel, mem_wr=cpu_mem_wr, busy=0.
  - If any exc_* is high at a clock edge: latch exc_cause, go to SAVE.
  - Priority when several are high: opcode > overflow > div0.
- SAVE (1 cycle):
  - epc_write=1, busy=1, mem_wr=0.
  - iord_sel=vector select for exc_cause.
  - Load wait counter with MEM_WAIT.
  - Go to WAIT.
- WAIT:
  - busy=1, mem_wr=0, iord_sel held at the vector select.
  - Counter decrements each cycle; leave for LOAD in the cycle the counter reaches 1. WAIT therefore lasts exactly MEM_WAIT cycles.
- LOAD (1 cycle):
  - pc_write=1, pc_data={24'b0, mem_data[7:0]} (zero-extend, upper mem_data bits ignored).
  - iord_sel held at the vector select, busy=1, mem_wr=0.
  - Go to DONE.
- DONE (1 cycle):
  - done=1, busy=0.
  - iord_sel and mem_wr revert to pass-through.
  - Go to IDLE. New exceptions are not sampled in DONE.
- exc_cause holds its value after DONE until the next exception latches a new cause or reset clears it.
- pc_data holds its last value outside LOAD. Only pc_write qualifies it.
- Latency: exception seen at edge N gives
  - SAVE in cycle N+1;
  - LOAD in cycle N+2+MEM_WAIT;
  - done in cycle N+3+MEM_WAIT;
  - IDLE in cycle N+4+MEM_WAIT.
- exc_* inputs while not in IDLE are ignored and not queued. A request still high on return to IDLE is taken at the next edge.
- mem_wr is forced to 0 in SAVE, WAIT and LOAD regardless of cpu_mem_wr. The vector fetch is never a write.
- Reset asserted in any state:
  - IDLE at the next edge, registers cleared;
  - no pc_write or done is issued for the aborted sequence.

Test Plan:
1. Reset, MEM_WAIT=1, cpu_iord_sel=101, cpu_mem_wr=1, no exceptions -> iord_sel=101, mem_wr=1, busy=0, exc_cause=00.
2. exc_overflow pulsed 1 cycle, mem_data=32'hFFFF_FF3C -> 1 cycle epc_write with iord_sel=010; WAIT 1 cycle; LOAD with pc_write=1, pc_data=32'h0000_003C; done at N+4; exc_cause=10.
3. exc_opcode, exc_overflow and exc_div0 high together -> iord_sel=001, exc_cause=01; repeat with only overflow and div0 high -> iord_sel=010.
4. MEM_WAIT=3, exc_div0 -> iord_sel=011 for SAVE, 3 WAIT cycles and LOAD; pc_write at N+5; cpu_mem_wr=1 throughout yet mem_wr=0 from SAVE through LOAD.
5. exc_opcode asserted during WAIT of a div0 sequence, then dropped before DONE -> ignored; exc_cause stays 11; single pc_write.
6. reset asserted in WAIT -> next cycle IDLE, busy=0, exc_cause=00; no pc_write and no done pulse for that sequence.
